// File: rtl/llc_msg_out_queue_pkg.sv
// Shared types for the LLC outbound message queue: packed response message,
// its width, default queue geometry and the arbiter lock state.
package llc_msg_out_queue_pkg;

    typedef struct packed {
        logic [3:0]  coh_msg;
        logic [3:0]  req_id;
        logic [1:0]  word_offset;
        logic [21:0] addr;
        logic [31:0] line;
    } llc_rsp_out_t;

    localparam int unsigned LLC_RSP_OUT_W   = $bits(llc_rsp_out_t);
    localparam int unsigned LLC_MSGQ_NUM_CH = 2;
    localparam int unsigned LLC_MSGQ_DEPTH  = 4;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/llc_msgq_fifo.sv
// Single-channel message FIFO with occupancy count; DEPTH need not be a power of two.
module llc_msgq_fifo
    import llc_msg_out_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = LLC_MSGQ_DEPTH,
    parameter  int unsigned MSG_W = LLC_RSP_OUT_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [MSG_W-1:0] wdata_i,
    output logic [MSG_W-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MSG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    // Full FIFO refuses a push even when popped the same cycle.
    assign do_push = push_i && (cnt_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the top masks the head whenever nothing is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/llc_msg_out_queue.sv
// Per-channel LLC message queues merged onto one network port by a locking round-robin arbiter.
// Define LLC_MSGQ_STRICT_PRIO_EN to give channel 0 strict priority over the others.
module llc_msg_out_queue
    import llc_msg_out_queue_pkg::*;
#(
    parameter  int unsigned NUM_CH = LLC_MSGQ_NUM_CH,
    parameter  int unsigned DEPTH  = LLC_MSGQ_DEPTH,
    parameter  int unsigned MSG_W  = LLC_RSP_OUT_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [NUM_CH*MSG_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MSG_W-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic [NUM_CH*CNT_W-1:0] occ
);

`ifdef LLC_MSGQ_STRICT_PRIO_EN
    localparam bit STRICT_PRIO = 1'b1;
`else
    localparam bit STRICT_PRIO = 1'b0;
`endif

    arb_state_e       state_q, state_d;
    logic [CH_W-1:0]  last_pop_q, last_pop_d;
    logic [CH_W-1:0]  hold_ch_q, hold_ch_d;
    logic [CH_W-1:0]  pick_ch;
    logic [CH_W-1:0]  grant_ch;
    logic             pick_found;
    int unsigned      idx;
    logic             fire;
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] pop;
    logic [MSG_W-1:0] head [NUM_CH];
    logic [CNT_W-1:0] cnt  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        llc_msgq_fifo #(
            .DEPTH (DEPTH),
            .MSG_W (MSG_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst),
            .push_i  (in_valid[g] && in_ready[g]),
            .pop_i   (pop[g]),
            .wdata_i (in_data[g*MSG_W +: MSG_W]),
            .head_o  (head[g]),
            .count_o (cnt[g])
        );

        assign in_ready[g]               = (cnt[g] != CNT_W'(DEPTH));
        assign nonempty[g]               = (cnt[g] != '0);
        assign pop[g]                    = fire && (grant_ch == CH_W'(g));
        assign occ[g*CNT_W +: CNT_W]     = cnt[g];
    end

    // Round-robin search starting after the last popped channel.
    always_comb begin
        pick_ch    = '0;
        pick_found = 1'b0;
        idx        = 0;
        if (STRICT_PRIO && nonempty[0]) begin
            pick_found = 1'b1;
        end
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(last_pop_q) + 32'd1 + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!pick_found && nonempty[CH_W'(idx)] && !(STRICT_PRIO && (idx == 0))) begin
                pick_found = 1'b1;
                pick_ch    = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock the grant while the network stalls an offered message.
    always_comb begin
        state_d = ARB_FREE;
        if (out_valid && !out_ready) begin
            state_d = ARB_HOLD;
        end
    end

    always_comb begin
        grant_ch   = pick_ch;
        if (state_q == ARB_HOLD) begin
            grant_ch = hold_ch_q;
        end
        out_valid  = |nonempty;
        fire       = out_valid && out_ready;
        out_ch     = grant_ch;
        out_data   = out_valid ? head[grant_ch] : '0;
        hold_ch_d  = grant_ch;
        last_pop_d = fire ? grant_ch : last_pop_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_ch_q  <= '0;
            last_pop_q <= CH_W'(NUM_CH - 1);
        end else begin
            hold_ch_q  <= hold_ch_d;
            last_pop_q <= last_pop_d;
        end
    end

endmodule

// File: tb/tb_llc_msg_out_queue.sv
// Self-checking bench for llc_msg_out_queue against a queue-based reference model.
module tb_llc_msg_out_queue;
    import llc_msg_out_queue_pkg::*;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MSG_W  = LLC_RSP_OUT_W;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned CH_W   = 1;
`ifdef LLC_MSGQ_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*MSG_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [MSG_W-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic [NUM_CH*CNT_W-1:0] occ;

    always #5 clk = ~clk;

    llc_msg_out_queue #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .MSG_W  (MSG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .occ       (occ)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per channel plus round-robin pointer and stall lock.
    logic [MSG_W-1:0] mq [NUM_CH][$];
    int               last_pop;
    bit               held;
    int               held_ch;
    int               dut_pop_ch[$];
    logic [MSG_W-1:0] dut_pop_data[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [MSG_W-1:0] rnd_msg();
        return MSG_W'({$urandom(), $urandom()});
    endfunction

    function automatic int model_pick();
        int c;
        if (STRICT && mq[0].size() != 0) return 0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            c = (last_pop + k) % int'(NUM_CH);
            if (!(STRICT && c == 0) && mq[c].size() != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < int'(NUM_CH); c++) mq[c].delete();
        last_pop = int'(NUM_CH) - 1;
        held     = 1'b0;
        held_ch  = 0;
    endtask

    task automatic set_data(input int c, input logic [MSG_W-1:0] d);
        in_data[c*MSG_W +: MSG_W] = d;
    endtask

    // One clock: compare outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        bit                      ev;
        int                      ech;
        bit                      acc [NUM_CH];
        logic [NUM_CH-1:0]       erdy;
        logic [NUM_CH*CNT_W-1:0] eocc;
        logic [MSG_W-1:0]        d;
        @(negedge clk);
        ev = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) if (mq[c].size() != 0) ev = 1'b1;
        ech = held ? held_ch : model_pick();
        check_eq("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            check_eq("out_ch", 64'(out_ch), 64'(ech));
            check_eq("out_data", 64'(out_data), 64'(mq[ech][0]));
            if (out_ready) begin
                dut_pop_ch.push_back(int'(out_ch));
                dut_pop_data.push_back(out_data);
            end
        end
        eocc = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            eocc[c*CNT_W +: CNT_W] = CNT_W'(mq[c].size());
            erdy[c] = (mq[c].size() != int'(DEPTH));
        end
        check_eq("in_ready", 64'(in_ready), 64'(erdy));
        check_eq("occ", 64'(occ), 64'(eocc));
        @(posedge clk);
        for (int c = 0; c < int'(NUM_CH); c++) acc[c] = in_valid[c] && (mq[c].size() < int'(DEPTH));
        if (ev && out_ready) begin
            d = mq[ech].pop_front();
            last_pop = ech;
        end
        held    = ev && !out_ready;
        held_ch = ech;
        for (int c = 0; c < int'(NUM_CH); c++) if (acc[c]) mq[c].push_back(in_data[c*MSG_W +: MSG_W]);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        out_ready = 1'b0;
        rst       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_occ", 64'(occ), 64'(0));
        rst = 1'b1;
        model_reset();
        check_eq("rst_in_ready", 64'(in_ready), 64'({NUM_CH{1'b1}}));
    endtask

    initial begin
        logic [MSG_W-1:0] d;
        logic [MSG_W-1:0] sent[$];
        int               exp_seq [6];

        rst      = 1'b0;
        in_valid = '0;
        in_data  = '0;
        out_ready = 1'b0;
        model_reset();
        do_reset();

        // Single push on channel 1, popped next cycle.
        d = rnd_msg();
        set_data(1, d);
        set_data(0, rnd_msg());
        in_valid = 2'b10;
        tick();
        in_valid = '0;
        check_eq("t17_valid", 64'(out_valid), 64'(1));
        check_eq("t17_ch", 64'(out_ch), 64'(1));
        check_eq("t17_data", 64'(out_data), 64'(d));
        out_ready = 1'b1;
        tick();
        check_eq("t17_occ", 64'(occ), 64'(0));

        // Fill channel 0, over-push, then drain in order.
        do_reset();
        sent.delete();
        for (int i = 0; i < 5; i++) begin
            d = rnd_msg();
            if (i < 4) sent.push_back(d);
            set_data(0, d);
            in_valid = 2'b01;
            tick();
            if (i == 3) check_eq("t18_full_ready", 64'(in_ready[0]), 64'(0));
        end
        in_valid = '0;
        check_eq("t18_occ", 64'(occ[CNT_W-1:0]), 64'(4));
        dut_pop_data.delete();
        dut_pop_ch.delete();
        out_ready = 1'b1;
        repeat (5) tick();
        check_eq("t18_npop", 64'(dut_pop_data.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            check_eq("t18_order", (i < dut_pop_data.size()) ? 64'(dut_pop_data[i]) : 64'hdead, 64'(sent[i]));

        // Three messages on both channels: arbitration order.
        do_reset();
        in_valid = 2'b11;
        repeat (3) begin
            set_data(0, rnd_msg());
            set_data(1, rnd_msg());
            tick();
        end
        in_valid = '0;
        dut_pop_ch.delete();
        out_ready = 1'b1;
        repeat (6) tick();
        if (STRICT) exp_seq = '{0, 0, 0, 1, 1, 1};
        else        exp_seq = '{0, 1, 0, 1, 0, 1};
        check_eq("t19_npop", 64'(dut_pop_ch.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            check_eq("t19_seq", (i < dut_pop_ch.size()) ? 64'(dut_pop_ch[i]) : 64'hdead, 64'(exp_seq[i]));

        // Stalled channel-1 head stays locked while channel 0 fills.
        do_reset();
        d = rnd_msg();
        set_data(1, d);
        in_valid = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1) ? 2'b01 : 2'b00;
            set_data(0, rnd_msg());
            tick();
            check_eq("t21_ch", 64'(out_ch), 64'(1));
            check_eq("t21_data", 64'(out_data), 64'(d));
        end
        in_valid = '0;
        dut_pop_ch.delete();
        out_ready = 1'b1;
        tick();
        check_eq("t21_pop_ch", (dut_pop_ch.size() > 0) ? 64'(dut_pop_ch[0]) : 64'hdead, 64'(1));
        tick();

        // Asynchronous reset with queued messages discards them.
        do_reset();
        in_valid = 2'b11;
        set_data(0, rnd_msg());
        set_data(1, rnd_msg());
        tick();
        in_valid = 2'b01;
        set_data(0, rnd_msg());
        tick();
        in_valid = '0;
        check_eq("t22_occ_pre", 64'(occ), 64'({3'd1, 3'd2}));
        #2;
        rst = 1'b0;
        #1;
        check_eq("t22_valid_async", 64'(out_valid), 64'(0));
        check_eq("t22_occ", 64'(occ), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        dut_pop_ch.delete();
        out_ready = 1'b1;
        repeat (5) tick();
        check_eq("t22_no_emit", 64'(dut_pop_ch.size()), 64'(0));

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 2000; n++) begin
            in_valid  = NUM_CH'($urandom());
            for (int c = 0; c < int'(NUM_CH); c++) set_data(c, rnd_msg());
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (2 * DEPTH + 2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
